// File: rtl/axi_tdd_seq_counter_if.sv
// Configuration bus from the axi_tdd register bank (asy_* fields) into the
// sequence counter; the register bank drives, the counter samples.
interface axi_tdd_seq_counter_if #(
  parameter int REGISTER_WIDTH    = 32,
  parameter int BURST_COUNT_WIDTH = 32,
  parameter int FRAME_SLOTS       = 4
);
  localparam int SLOT_W = (FRAME_SLOTS > 1) ? $clog2(FRAME_SLOTS) : 1;

  logic [BURST_COUNT_WIDTH-1:0]          asy_tdd_burst_count;
  logic [REGISTER_WIDTH-1:0]             asy_tdd_startup_delay;
  logic [SLOT_W:0]                       asy_tdd_slot_count;
  logic [FRAME_SLOTS*REGISTER_WIDTH-1:0] asy_tdd_frame_length;

  modport master (
    output asy_tdd_burst_count,
    output asy_tdd_startup_delay,
    output asy_tdd_slot_count,
    output asy_tdd_frame_length
  );

  modport slave (
    input asy_tdd_burst_count,
    input asy_tdd_startup_delay,
    input asy_tdd_slot_count,
    input asy_tdd_frame_length
  );
endinterface

// File: rtl/axi_tdd_seq_counter.sv
// TDD sequence timebase: plays a cyclic sequence of per-slot frame lengths,
// in finite bursts or continuously. Optional resync enabled by AXI_TDD_SEQ_RESYNC_EN.
package axi_tdd_pkg;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    WAITING = 2'd2,
    RUNNING = 2'd3
  } state_t;
endpackage

module axi_tdd_seq_counter
  import axi_tdd_pkg::*;
#(
  parameter int REGISTER_WIDTH    = 32,
  parameter int BURST_COUNT_WIDTH = 32,
  parameter int FRAME_SLOTS       = 4,
  localparam int SLOT_W           = (FRAME_SLOTS > 1) ? $clog2(FRAME_SLOTS) : 1
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       tdd_enable,
  input  logic                       tdd_sync,
  axi_tdd_seq_counter_if.slave       cfg,
  output logic                       tdd_active,
  output logic [REGISTER_WIDTH-1:0]  tdd_counter,
  output state_t                     tdd_cstate,
  output logic [SLOT_W-1:0]          tdd_slot,
  output logic                       tdd_endof_frame,
  output logic                       tdd_endof_burst,
  output logic [REGISTER_WIDTH-1:0]  tdd_frame_count
);
  localparam logic [REGISTER_WIDTH-1:0]    RW_ZERO = {REGISTER_WIDTH{1'b0}};
  localparam logic [REGISTER_WIDTH-1:0]    RW_ONE  = {{(REGISTER_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [BURST_COUNT_WIDTH-1:0] BC_ZERO = {BURST_COUNT_WIDTH{1'b0}};
  localparam logic [BURST_COUNT_WIDTH-1:0] BC_ONE  = {{(BURST_COUNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [SLOT_W-1:0]            SL_ZERO = {SLOT_W{1'b0}};
  localparam logic [SLOT_W-1:0]            SL_ONE  = {{(SLOT_W-1){1'b0}}, 1'b1};
  localparam logic [SLOT_W:0]              SC_ONE  = {{SLOT_W{1'b0}}, 1'b1};
  localparam logic [SLOT_W:0]              SC_MAX  = (SLOT_W+1)'(FRAME_SLOTS);

  state_t                         state_r, state_s;
  logic [REGISTER_WIDTH-1:0]      counter_r, counter_s;
  logic [SLOT_W-1:0]              slot_r, slot_s;
  logic [REGISTER_WIDTH-1:0]      fcnt_r, fcnt_s;
  logic [BURST_COUNT_WIDTH-1:0]   remaining_r, remaining_s;

  logic [BURST_COUNT_WIDTH-1:0]   burst_r;
  logic [REGISTER_WIDTH-1:0]      delay_r;
  logic [SLOT_W:0]                nslot_r;
  logic [REGISTER_WIDTH-1:0]      len_r [FRAME_SLOTS];

  logic                           load_s;
  logic [REGISTER_WIDTH-1:0]      cur_len_s;
  logic                           frame_last_s;
  logic                           seq_last_s;
  logic                           finite_s;
  logic                           resync_s;
  state_t                         restart_s;

  function automatic logic [SLOT_W:0] clamp_slots(input logic [SLOT_W:0] n);
    if (n == {(SLOT_W+1){1'b0}}) begin
      return SC_ONE;
    end else if (n > SC_MAX) begin
      return SC_MAX;
    end else begin
      return n;
    end
  endfunction

  assign load_s       = tdd_enable && ((state_r == IDLE) || (state_r == ARMED));
  assign cur_len_s    = len_r[slot_r];
  // A programmed length of 0 behaves as a single-cycle frame.
  assign frame_last_s = (cur_len_s <= RW_ONE) || (counter_r == (cur_len_s - RW_ONE));
  assign seq_last_s   = ({1'b0, slot_r} == (nslot_r - SC_ONE));
  assign finite_s     = (burst_r != BC_ZERO);
  assign restart_s    = (delay_r != RW_ZERO) ? WAITING : RUNNING;

`ifdef AXI_TDD_SEQ_RESYNC_EN
  assign resync_s = tdd_sync && ((state_r == WAITING) || (state_r == RUNNING));
`else
  assign resync_s = 1'b0;
`endif

  assign tdd_active      = (state_r == RUNNING);
  assign tdd_counter     = counter_r;
  assign tdd_cstate      = state_r;
  assign tdd_slot        = slot_r;
  assign tdd_frame_count = fcnt_r;
  assign tdd_endof_frame = (state_r == RUNNING) && frame_last_s && !resync_s;
  assign tdd_endof_burst = tdd_endof_frame && seq_last_s && finite_s && (remaining_r == BC_ONE);

  // Next-state and datapath update for the sequencer
  always_comb begin
    state_s     = state_r;
    counter_s   = counter_r;
    slot_s      = slot_r;
    fcnt_s      = fcnt_r;
    remaining_s = remaining_r;
    case (state_r)
      IDLE: begin
        counter_s = RW_ZERO;
        slot_s    = SL_ZERO;
        fcnt_s    = RW_ZERO;
        if (tdd_enable) begin
          state_s = ARMED;
        end else begin
          state_s = IDLE;
        end
      end
      ARMED: begin
        counter_s   = RW_ZERO;
        slot_s      = SL_ZERO;
        fcnt_s      = RW_ZERO;
        // Shadows load this same cycle, so decide from the live register bank.
        remaining_s = cfg.asy_tdd_burst_count;
        if (!tdd_enable) begin
          state_s = IDLE;
        end else if (tdd_sync) begin
          state_s = (cfg.asy_tdd_startup_delay != RW_ZERO) ? WAITING : RUNNING;
        end else begin
          state_s = ARMED;
        end
      end
      WAITING: begin
        if (!tdd_enable) begin
          state_s   = IDLE;
          counter_s = RW_ZERO;
        end else if (resync_s) begin
          state_s   = restart_s;
          counter_s = RW_ZERO;
          slot_s    = SL_ZERO;
        end else if (counter_r == (delay_r - RW_ONE)) begin
          state_s   = RUNNING;
          counter_s = RW_ZERO;
        end else begin
          counter_s = counter_r + RW_ONE;
        end
      end
      RUNNING: begin
        if (resync_s) begin
          state_s   = restart_s;
          counter_s = RW_ZERO;
          slot_s    = SL_ZERO;
        end else if (frame_last_s) begin
          counter_s = RW_ZERO;
          fcnt_s    = fcnt_r + RW_ONE;
          if (seq_last_s) begin
            slot_s = SL_ZERO;
            if (finite_s) begin
              remaining_s = remaining_r - BC_ONE;
              if (remaining_r == BC_ONE) begin
                fcnt_s  = RW_ZERO;
                state_s = tdd_enable ? ARMED : IDLE;
              end else begin
                state_s = RUNNING;
              end
            end else begin
              state_s = tdd_enable ? RUNNING : IDLE;
            end
          end else begin
            slot_s = slot_r + SL_ONE;
          end
        end else begin
          counter_s = counter_r + RW_ONE;
        end
      end
      default: begin
        state_s   = IDLE;
        counter_s = RW_ZERO;
        slot_s    = SL_ZERO;
      end
    endcase
  end

  // Sequencer state and datapath registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r     <= IDLE;
      counter_r   <= RW_ZERO;
      slot_r      <= SL_ZERO;
      fcnt_r      <= RW_ZERO;
      remaining_r <= BC_ZERO;
    end else begin
      state_r     <= state_s;
      counter_r   <= counter_s;
      slot_r      <= slot_s;
      fcnt_r      <= fcnt_s;
      remaining_r <= remaining_s;
    end
  end

  // Shadow copies of the register bank, frozen once a burst is under way
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      burst_r <= BC_ZERO;
      delay_r <= RW_ZERO;
      nslot_r <= {(SLOT_W+1){1'b0}};
      for (int i = 0; i < FRAME_SLOTS; i++) begin
        len_r[i] <= RW_ZERO;
      end
    end else if (load_s) begin
      burst_r <= cfg.asy_tdd_burst_count;
      delay_r <= cfg.asy_tdd_startup_delay;
      nslot_r <= clamp_slots(cfg.asy_tdd_slot_count);
      for (int i = 0; i < FRAME_SLOTS; i++) begin
        len_r[i] <= cfg.asy_tdd_frame_length[i*REGISTER_WIDTH +: REGISTER_WIDTH];
      end
    end
  end
endmodule

// File: tb/tb_axi_tdd_seq_counter.sv
// Self-checking bench for axi_tdd_seq_counter: table vectors, hand sequences
// for latency/continuous/abort/resync/reset, and a randomized schedule model.
`timescale 1ns/1ps
module tb_axi_tdd_seq_counter;
  import axi_tdd_pkg::*;

  localparam int RW = 32;
  localparam int BW = 32;
  localparam int FS = 4;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          tdd_enable = 1'b0;
  logic          tdd_sync = 1'b0;
  logic          tdd_active;
  logic [RW-1:0] tdd_counter;
  state_t        tdd_cstate;
  logic [SW-1:0] tdd_slot;
  logic          tdd_endof_frame;
  logic          tdd_endof_burst;
  logic [RW-1:0] tdd_frame_count;

  int n_cmp = 0;
  int n_err = 0;

  axi_tdd_seq_counter_if #(.REGISTER_WIDTH(RW), .BURST_COUNT_WIDTH(BW), .FRAME_SLOTS(FS)) cfg_if ();

  axi_tdd_seq_counter #(.REGISTER_WIDTH(RW), .BURST_COUNT_WIDTH(BW), .FRAME_SLOTS(FS)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .tdd_enable      (tdd_enable),
    .tdd_sync        (tdd_sync),
    .cfg             (cfg_if),
    .tdd_active      (tdd_active),
    .tdd_counter     (tdd_counter),
    .tdd_cstate      (tdd_cstate),
    .tdd_slot        (tdd_slot),
    .tdd_endof_frame (tdd_endof_frame),
    .tdd_endof_burst (tdd_endof_burst),
    .tdd_frame_count (tdd_frame_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int slots; int l0; int l1; int l2; int l3; int dly; int burst;
    int exp_wait; int exp_run; int exp_eof; int exp_slot;
  } vec_t;

  typedef struct {
    state_t st; int cnt; int slot; bit eof; bit eob; int fc;
  } exp_t;

  vec_t vecs [6];
  exp_t exp_q [$];
  int   m_len [4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input int slots, input int l0, input int l1, input int l2,
                         input int l3, input int dly, input int burst);
    cfg_if.asy_tdd_slot_count    = 3'(slots);
    cfg_if.asy_tdd_frame_length  = {32'(l3), 32'(l2), 32'(l1), 32'(l0)};
    cfg_if.asy_tdd_startup_delay = 32'(dly);
    cfg_if.asy_tdd_burst_count   = 32'(burst);
  endtask

  // Expand the whole burst into the expected per-cycle schedule.
  task automatic build_model(input int slots, input int dly, input int burst);
    int   ns;
    int   fc;
    int   len;
    exp_t e;
    ns = (slots == 0) ? 1 : ((slots > FS) ? FS : slots);
    exp_q.delete();
    for (int w = 0; w < dly; w++) begin
      e = '{WAITING, w, 0, 1'b0, 1'b0, 0};
      exp_q.push_back(e);
    end
    fc = 0;
    for (int b = 0; b < burst; b++) begin
      for (int s = 0; s < ns; s++) begin
        len = (m_len[s] == 0) ? 1 : m_len[s];
        for (int c = 0; c < len; c++) begin
          e.st   = RUNNING;
          e.cnt  = c;
          e.slot = s;
          e.eof  = (c == len - 1);
          e.eob  = (c == len - 1) && (s == ns - 1) && (b == burst - 1);
          e.fc   = fc;
          exp_q.push_back(e);
        end
        fc++;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nw, nr, ne, nb, eob_at, eob_slot;
    bit done;

    vecs[0] = '{3, 4, 2, 3, 0, 0, 2, 0, 18, 6, 2};
    vecs[1] = '{1, 5, 0, 0, 0, 3, 1, 3, 5, 1, 0};
    vecs[2] = '{7, 2, 0, 1, 3, 0, 1, 0, 7, 4, 3};
    vecs[3] = '{0, 3, 9, 9, 9, 2, 3, 2, 9, 3, 0};
    vecs[4] = '{2, 1, 1, 0, 0, 1, 2, 1, 4, 4, 1};
    vecs[5] = '{4, 1, 2, 0, 2, 4, 1, 4, 6, 4, 3};

    set_cfg(3, 4, 2, 3, 0, 0, 2);
    #3;
    check("rst_state", 64'(tdd_cstate), 64'(IDLE));
    check("rst_counter", 64'(tdd_counter), 64'd0);
    check("rst_slot", 64'(tdd_slot), 64'd0);
    check("rst_active", 64'(tdd_active), 64'd0);
    check("rst_eof", 64'(tdd_endof_frame), 64'd0);
    check("rst_eob", 64'(tdd_endof_burst), 64'd0);
    check("rst_fcnt", 64'(tdd_frame_count), 64'd0);
    #10 resetn = 1'b1;
    tdd_enable = 1'b1;
    next_cycle();
    next_cycle();
    check("arm_state", 64'(tdd_cstate), 64'(ARMED));

    // Table-driven bursts
    for (int v = 0; v < 6; v++) begin
      set_cfg(vecs[v].slots, vecs[v].l0, vecs[v].l1, vecs[v].l2, vecs[v].l3, vecs[v].dly, vecs[v].burst);
      next_cycle();
      next_cycle();
      tdd_sync = 1'b1;
      next_cycle();
      tdd_sync = 1'b0;
      nw = 0; nr = 0; ne = 0; nb = 0; eob_at = -1; eob_slot = -1; done = 1'b0;
      for (int k = 0; k < 300; k++) begin
        #1;
        if (tdd_cstate == WAITING) begin
          nw++;
        end else if (tdd_cstate == RUNNING) begin
          nr++;
          if (tdd_endof_frame) ne++;
          if (tdd_endof_burst) begin
            nb++; eob_at = nr; eob_slot = int'(tdd_slot);
          end
        end else begin
          done = 1'b1;
          break;
        end
        next_cycle();
      end
      check("tbl_done", 64'(done), 64'd1);
      check("tbl_end_state", 64'(tdd_cstate), 64'(ARMED));
      check("tbl_wait", 64'(nw), 64'(vecs[v].exp_wait));
      check("tbl_run", 64'(nr), 64'(vecs[v].exp_run));
      check("tbl_eof", 64'(ne), 64'(vecs[v].exp_eof));
      check("tbl_eob_cnt", 64'(nb), 64'd1);
      check("tbl_eob_at", 64'(eob_at), 64'(vecs[v].exp_run));
      check("tbl_eob_slot", 64'(eob_slot), 64'(vecs[v].exp_slot));
    end

    // Startup delay latency, then enable drop during the last sequence
    set_cfg(1, 3, 0, 0, 0, 5, 1);
    next_cycle();
    next_cycle();
    tdd_sync = 1'b1;
    next_cycle();
    tdd_sync = 1'b0;
    for (int j = 1; j <= 5; j++) begin
      #1;
      check("dly_wait_state", 64'(tdd_cstate), 64'(WAITING));
      check("dly_wait_cnt", 64'(tdd_counter), 64'(j - 1));
      next_cycle();
    end
    #1;
    check("dly_run_state", 64'(tdd_cstate), 64'(RUNNING));
    check("dly_run_cnt", 64'(tdd_counter), 64'd0);
    tdd_enable = 1'b0;
    next_cycle(); #1;
    check("dly_cnt1", 64'(tdd_counter), 64'd1);
    next_cycle(); #1;
    check("dly_cnt2", 64'(tdd_counter), 64'd2);
    check("dly_eob", 64'(tdd_endof_burst), 64'd1);
    next_cycle(); #1;
    check("dly_idle", 64'(tdd_cstate), 64'(IDLE));
    tdd_enable = 1'b1;
    next_cycle();
    next_cycle();

    // Continuous mode: enable drop mid-frame ends after that frame
    set_cfg(1, 8, 0, 0, 0, 0, 0);
    next_cycle();
    next_cycle();
    tdd_sync = 1'b1;
    next_cycle();
    tdd_sync = 1'b0;
    for (int i = 0; i < 16; i++) begin
      #1;
      check("cont_state", 64'(tdd_cstate), 64'(RUNNING));
      check("cont_cnt", 64'(tdd_counter), 64'(i % 8));
      check("cont_eof", 64'(tdd_endof_frame), 64'((i % 8) == 7));
      check("cont_eob", 64'(tdd_endof_burst), 64'd0);
      check("cont_fcnt", 64'(tdd_frame_count), 64'(i / 8));
      if (i == 11) tdd_enable = 1'b0;
      next_cycle();
    end
    #1;
    check("cont_idle", 64'(tdd_cstate), 64'(IDLE));
    check("cont_active", 64'(tdd_active), 64'd0);
    tdd_enable = 1'b1;
    next_cycle();
    next_cycle();

    // Abort while waiting
    set_cfg(1, 4, 0, 0, 0, 5, 1);
    next_cycle();
    next_cycle();
    tdd_sync = 1'b1;
    next_cycle();
    tdd_sync = 1'b0;
    #1;
    check("abort_wait", 64'(tdd_cstate), 64'(WAITING));
    tdd_enable = 1'b0;
    next_cycle(); #1;
    check("abort_idle", 64'(tdd_cstate), 64'(IDLE));
    tdd_enable = 1'b1;
    next_cycle();
    next_cycle();

    // Sync while running: restart with the macro, ignored without it
    set_cfg(1, 10, 0, 0, 0, 0, 1);
    next_cycle();
    next_cycle();
    tdd_sync = 1'b1;
    next_cycle();
    tdd_sync = 1'b0;
    repeat (6) next_cycle();
    #1;
    check("rs_cnt6", 64'(tdd_counter), 64'd6);
    tdd_sync = 1'b1;
    #1;
    check("rs_eof_mid", 64'(tdd_endof_frame), 64'd0);
    next_cycle();
    tdd_sync = 1'b0;
    #1;
`ifdef AXI_TDD_SEQ_RESYNC_EN
    check("rs_restart_cnt", 64'(tdd_counter), 64'd0);
    check("rs_restart_slot", 64'(tdd_slot), 64'd0);
    check("rs_restart_state", 64'(tdd_cstate), 64'(RUNNING));
    repeat (9) next_cycle();
    #1;
    check("rs_cnt9", 64'(tdd_counter), 64'd9);
    tdd_sync = 1'b1;
    #1;
    check("rs_eof_suppr", 64'(tdd_endof_frame), 64'd0);
    check("rs_eob_suppr", 64'(tdd_endof_burst), 64'd0);
    next_cycle();
    tdd_sync = 1'b0;
    #1;
    check("rs_edge_cnt", 64'(tdd_counter), 64'd0);
    check("rs_edge_state", 64'(tdd_cstate), 64'(RUNNING));
    check("rs_edge_fcnt", 64'(tdd_frame_count), 64'd0);
    repeat (9) next_cycle();
    #1;
    check("rs_final_eob", 64'(tdd_endof_burst), 64'd1);
    next_cycle();
    #1;
    check("rs_final_state", 64'(tdd_cstate), 64'(ARMED));
`else
    check("rs_ignored_cnt", 64'(tdd_counter), 64'd7);
    next_cycle();
    next_cycle();
    #1;
    check("rs_cnt9", 64'(tdd_counter), 64'd9);
    tdd_sync = 1'b1;
    #1;
    check("rs_eof_last", 64'(tdd_endof_frame), 64'd1);
    check("rs_eob_last", 64'(tdd_endof_burst), 64'd1);
    next_cycle();
    tdd_sync = 1'b0;
    #1;
    check("rs_final_state", 64'(tdd_cstate), 64'(ARMED));
`endif

    // Randomized bursts against the expanded schedule; bank writes mid-burst
    for (int t = 0; t < 25; t++) begin
      int slots, dly, burst;
      slots = int'($urandom_range(0, 7));
      dly   = int'($urandom_range(0, 6));
      burst = int'($urandom_range(1, 3));
      for (int s = 0; s < 4; s++) m_len[s] = int'($urandom_range(0, 5));
      set_cfg(slots, m_len[0], m_len[1], m_len[2], m_len[3], dly, burst);
      build_model(slots, dly, burst);
      next_cycle();
      next_cycle();
      tdd_sync = 1'b1;
      next_cycle();
      tdd_sync = 1'b0;
      for (int i = 0; i < exp_q.size(); i++) begin
        #1;
        check("rnd_state", 64'(tdd_cstate), 64'(exp_q[i].st));
        check("rnd_cnt", 64'(tdd_counter), 64'(exp_q[i].cnt));
        check("rnd_slot", 64'(tdd_slot), 64'(exp_q[i].slot));
        check("rnd_eof", 64'(tdd_endof_frame), 64'(exp_q[i].eof));
        check("rnd_eob", 64'(tdd_endof_burst), 64'(exp_q[i].eob));
        check("rnd_fcnt", 64'(tdd_frame_count), 64'(exp_q[i].fc));
        if ($urandom_range(0, 2) == 0) begin
          set_cfg(int'($urandom_range(0, 7)), int'($urandom_range(0, 9)), int'($urandom_range(0, 9)),
                  int'($urandom_range(0, 9)), int'($urandom_range(0, 9)),
                  int'($urandom_range(0, 9)), int'($urandom_range(0, 4)));
        end
        next_cycle();
      end
      #1;
      check("rnd_end_state", 64'(tdd_cstate), 64'(ARMED));
      check("rnd_end_fcnt", 64'(tdd_frame_count), 64'd0);
    end

    // Asynchronous reset mid-WAITING and mid-RUNNING
    set_cfg(2, 6, 6, 0, 0, 4, 3);
    next_cycle();
    next_cycle();
    tdd_sync = 1'b1;
    next_cycle();
    tdd_sync = 1'b0;
    next_cycle();
    #1;
    check("ar_wait_cnt", 64'(tdd_counter), 64'd1);
    #2 resetn = 1'b0;
    #1;
    check("ar_w_state", 64'(tdd_cstate), 64'(IDLE));
    check("ar_w_cnt", 64'(tdd_counter), 64'd0);
    check("ar_w_active", 64'(tdd_active), 64'd0);
    #2 resetn = 1'b1;
    next_cycle();
    next_cycle();
    tdd_sync = 1'b1;
    next_cycle();
    tdd_sync = 1'b0;
    repeat (12) next_cycle();
    #1;
    check("ar_r_pre_state", 64'(tdd_cstate), 64'(RUNNING));
    check("ar_r_pre_slot", 64'(tdd_slot), 64'd1);
    check("ar_r_pre_cnt", 64'(tdd_counter), 64'd2);
    check("ar_r_pre_fcnt", 64'(tdd_frame_count), 64'd1);
    #2 resetn = 1'b0;
    #1;
    check("ar_r_state", 64'(tdd_cstate), 64'(IDLE));
    check("ar_r_cnt", 64'(tdd_counter), 64'd0);
    check("ar_r_slot", 64'(tdd_slot), 64'd0);
    check("ar_r_fcnt", 64'(tdd_frame_count), 64'd0);
    check("ar_r_active", 64'(tdd_active), 64'd0);
    check("ar_r_eof", 64'(tdd_endof_frame), 64'd0);
    check("ar_r_eob", 64'(tdd_endof_burst), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
